// File: rtl/tetris_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tetris_board_renderer
// Purpose  : Walks the 10x20 board memory and paints each cell as a 5x5 pixel
//            tile (4x4 cell colour plus a grid line) into a 160x120 VGA buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_board_renderer #(
    parameter int X0 = 55,
    parameter int Y0 = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] c_X0        = 8'(X0);
    localparam logic [6:0] c_Y0        = 7'(Y0);
    localparam logic [8:0] c_GRID      = 9'b010010010;
    localparam logic [7:0] c_LAST_CELL = 8'd199;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cell;
    logic [3:0] r_col;
    logic [4:0] r_row;
    logic [2:0] r_px;
    logic [2:0] r_py;
    logic [2:0] r_code;

    logic       w_px_end;
    logic       w_py_end;
    logic       w_last_cell;
    logic [7:0] w_col_off;
    logic [6:0] w_row_off;
    logic [8:0] w_palette;

    assign w_px_end    = (r_px == 3'd4);
    assign w_py_end    = (r_py == 3'd4);
    assign w_last_cell = (r_cell == c_LAST_CELL);

    // Row/column are tracked alongside the cell index to avoid a divider.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cell  <= 8'd0;
            r_col   <= 4'd0;
            r_row   <= 5'd0;
            r_px    <= 3'd0;
            r_py    <= 3'd0;
            r_code  <= 3'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cell <= 8'd0;
                        r_col  <= 4'd0;
                        r_row  <= 5'd0;
                        r_px   <= 3'd0;
                        r_py   <= 3'd0;
                    end
                end
                WAIT: begin
                    r_code <= rd_data;
                    r_px   <= 3'd0;
                    r_py   <= 3'd0;
                end
                DRAW: begin
                    if (w_px_end) begin
                        r_px <= 3'd0;
                        if (w_py_end) begin
                            r_py <= 3'd0;
                            if (!w_last_cell) begin
                                r_cell <= r_cell + 8'd1;
                                if (r_col == 4'd9) begin
                                    r_col <= 4'd0;
                                    r_row <= r_row + 5'd1;
                                end else begin
                                    r_col <= r_col + 4'd1;
                                end
                            end
                        end else begin
                            r_py <= r_py + 3'd1;
                        end
                    end else begin
                        r_px <= r_px + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        rd_en  = 1'b0;
        busy   = 1'b0;
        plot   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = FETCH;
            FETCH: begin
                rd_en  = 1'b1;
                busy   = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                busy   = 1'b1;
                w_next = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                plot = 1'b1;
                if (w_px_end && w_py_end) w_next = w_last_cell ? DONE : FETCH;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        case (r_code)
            3'd0:    w_palette = 9'b000000000;
            3'd1:    w_palette = 9'b000111111;
            3'd2:    w_palette = 9'b111111000;
            3'd3:    w_palette = 9'b101000111;
            3'd4:    w_palette = 9'b000111000;
            3'd5:    w_palette = 9'b111000000;
            3'd6:    w_palette = 9'b000000111;
            default: w_palette = 9'b111011000;
        endcase
    end

    assign w_col_off = 8'(r_col) * 8'd5;
    assign w_row_off = 7'(r_row) * 7'd5;
    assign rd_addr   = r_cell;
    assign x         = c_X0 + w_col_off + {5'b0, r_px};
    assign y         = c_Y0 + w_row_off + {4'b0, r_py};
    assign colour    = (w_px_end || w_py_end) ? c_GRID : w_palette;

endmodule
`default_nettype wire

// File: doc/tetris_board_renderer.md
TETRIS_BOARD_RENDERER -- requirements
Module: tetris_board_renderer

Interface
REQ-001 SHALL have parameter X0, default 55, meaning the framebuffer x of the playfield's left edge.
REQ-002 SHALL have parameter Y0, default 10, meaning the framebuffer y of the playfield's top edge.
REQ-003 SHALL have port clock, input, 1, the single system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to redraw the whole board.
REQ-006 SHALL have port rd_en, output, 1, the board-memory read strobe.
REQ-007 SHALL have port rd_addr, output, 8, the board cell index, row*10+col, range 0..199.
REQ-008 SHALL have port rd_data, input, 3, the cell colour code, valid in the cycle after rd_en.
REQ-009 SHALL have port x, output, 8, the pixel column into the 160x120 VGA adapter.
REQ-010 SHALL have port y, output, 7, the pixel row into the VGA adapter.
REQ-011 SHALL have port colour, output, 9, the pixel colour as RGB with 3 bits per channel.
REQ-012 SHALL have port plot, output, 1, the VGA adapter write enable; each cycle plot is high writes one pixel.
REQ-013 SHALL have port busy, output, 1, high while a redraw is in progress.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a redraw completes.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, DRAW, DONE.
REQ-016 SHALL, in IDLE, move to FETCH with cell=0 on a clock edge where start=1; otherwise it SHALL stay in IDLE.
REQ-017 SHALL hold rd_en=1 and rd_addr=cell in FETCH only; rd_en SHALL be 0 in every other state.
REQ-018 SHALL move from FETCH to WAIT unconditionally, and capture rd_data into the code register on the WAIT->DRAW edge.
REQ-019 SHALL, in DRAW, emit 25 consecutive plot=1 cycles per cell, with local py in 0..4 as the outer loop and px in 0..4 as the inner loop.
REQ-020 SHALL drive x=X0+col*5+px and y=Y0+row*5+py, with col=cell mod 10 and row=cell div 10; the arithmetic SHALL be unsigned and the result truncated to port width.
REQ-021 SHALL drive colour=9'b010010010 (grid colour) when px==4 or py==4; otherwise colour SHALL be palette[code].
REQ-022 SHALL use this palette: 0 black 000000000, 1 cyan 000111111, 2 yellow 111111000, 3 purple 101000111, 4 green 000111000, 5 red 111000000, 6 blue 000000111, 7 orange 111011000.
REQ-023 SHALL, after pixel (px=4, py=4): go to FETCH with cell+1 if cell<199, or go to DONE if cell==199.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL drive busy=1 in FETCH, WAIT and DRAW, and busy=0 in IDLE and DONE.
REQ-026 SHALL hold plot=0 outside DRAW; x, y and colour are don't-care when plot=0.
REQ-027 SHALL ignore start while busy=1 or in DONE; no restart and no queued request.
REQ-028 SHALL take exactly 27 cycles per cell, 5400 cycles FETCH-to-last-pixel per redraw, and write exactly 5000 pixels.
REQ-029 SHALL produce its first plot=1 cycle exactly 3 cycles after the start-sampling edge.

Reset
REQ-030 SHALL, on resetn=0 at any time including mid-redraw, immediately force state=IDLE, cell=0, px=py=0, code=0, rd_en=0, plot=0, busy=0, done=0.
REQ-031 SHALL, after resetn rises, stay in IDLE and produce no plot until a new start.

Verification
REQ-032 SHALL cover: reset, then start pulse with all cells code 0 -> 5000 plots; the first at (55,10) black; pixel (59,10) grid colour; the last at (104,109); done exactly once, 5401 cycles after the start edge.
REQ-033 SHALL cover: cell 0 code 2, rest 0 -> pixels x 55..58, y 10..13 colour 111111000; x=59 or y=14 colour 010010010.
REQ-034 SHALL cover: cell 199 code 5 -> pixel (100,105) colour 111000000; rd_addr sequence 0..199 strictly increasing, with rd_en high 200 cycles total.
REQ-035 SHALL cover: start re-pulsed at cycle 1000 of a redraw -> no change in the pixel sequence and a single done.
REQ-036 SHALL cover: resetn low at cycle 2000 of a redraw -> plot, busy and rd_en low in the same cycle; after release, no activity until start, then a full 5000-pixel redraw.
REQ-037 SHALL cover: X0=0, Y0=0 override -> first pixel (0,0), last pixel (49,99).
